// File: rtl/ctu_dbgbus_arb_rptr.sv
// N-channel debug-bus repeater/arbiter: fixed-priority or round-robin-with-hold
// selection, DEPTH-stage retiming pipeline, freeze/capture and a saturating
// drop counter.
module ctu_dbgbus_arb_rptr #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 40,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input  logic                    rclk,
    input  logic                    rst,
    input  logic                    mode_rr,
    input  logic                    freeze,
    input  logic                    clr_cnt,
    input  logic [NCH*(DW+1)-1:0]   dbgbus_in,
    output logic [DW-1:0]           dbgbus_out,
    output logic                    dbgbus_vld,
    output logic [CW-1:0]           dbgbus_chan,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned PW = $clog2(NCH + 1);

    logic [NCH-1:0] ch_vld;
    logic [DW-1:0]  ch_dat [NCH];
    logic [PW-1:0]  vld_cnt;

    logic [CW-1:0]  owner;
    logic           gnt_any;
    logic [CW-1:0]  gnt_idx;
    logic [DW-1:0]  gnt_dat;

    logic           pv [DEPTH];
    logic [CW-1:0]  pc [DEPTH];
    logic [DW-1:0]  pd [DEPTH];

    // Split the packed bus into per-channel valid/data and count valid channels
    always_comb begin
        vld_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_vld[i] = dbgbus_in[i*(DW+1) + DW];
            ch_dat[i] = dbgbus_in[i*(DW+1) +: DW];
            vld_cnt   = vld_cnt + PW'(ch_vld[i]);
        end
    end

    // Pick one channel: lowest valid index, or hold/rotate from the owner
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!mode_rr) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (ch_vld[CW'(i)] && !gnt_any) begin
                    gnt_any = 1'b1;
                    gnt_idx = CW'(i);
                end
            end
        end else if (ch_vld[owner]) begin
            gnt_any = 1'b1;
            gnt_idx = owner;
        end else begin
            // Wrap at NCH rather than 2^CW so non-power-of-2 channel counts
            // never probe a nonexistent index.
            for (int unsigned k = 1; k <= NCH; k++) begin
                idx = 32'(owner) + k;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (ch_vld[CW'(idx)] && !gnt_any) begin
                    gnt_any = 1'b1;
                    gnt_idx = CW'(idx);
                end
            end
        end
        gnt_dat = gnt_any ? ch_dat[gnt_idx] : '0;
    end

    // Owner tracks the last grant in either mode so mode switches keep history
    always_ff @(posedge rclk) begin
        if (rst) begin
            owner <= CW'(NCH - 1);
        end else if (!freeze && gnt_any) begin
            owner <= gnt_idx;
        end
    end

    // Retiming pipeline; everything holds while frozen
    always_ff @(posedge rclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pv[i] <= 1'b0;
                pc[i] <= '0;
                pd[i] <= '0;
            end
        end else if (!freeze) begin
            pv[0] <= gnt_any;
            pc[0] <= gnt_idx;
            pd[0] <= gnt_dat;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // Saturating drop counter; clear wins over freeze and over increment
    always_ff @(posedge rclk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr_cnt) begin
            drop_cnt <= '0;
        end else if (!freeze && vld_cnt >= PW'(2) && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign dbgbus_out  = pd[DEPTH-1];
    assign dbgbus_vld  = pv[DEPTH-1];
    assign dbgbus_chan = pc[DEPTH-1];

endmodule

// File: tb/tb_ctu_dbgbus_arb_rptr.sv
// Directed bench for ctu_dbgbus_arb_rptr: main DUT (NCH=4, DEPTH=2), a DEPTH=4
// twin on the same inputs, and an NCH=3 DEPTH=1 instance for index wrap.
module tb_ctu_dbgbus_arb_rptr;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode_rr;
    logic         freeze;
    logic         clr_cnt;
    logic [163:0] bus;
    logic [26:0]  bus3;

    logic [39:0]  out2, out4;
    logic         vld2, vld4;
    logic [1:0]   chan2, chan4;
    logic [7:0]   cnt2, cnt4;
    logic [7:0]   out3;
    logic         vld3;
    logic [1:0]   chan3;
    logic [7:0]   cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctu_dbgbus_arb_rptr #(.NCH(4), .DW(40), .DEPTH(2), .CW(2)) u_d2 (
        .rclk(clk), .rst(rst), .mode_rr(mode_rr), .freeze(freeze), .clr_cnt(clr_cnt),
        .dbgbus_in(bus), .dbgbus_out(out2), .dbgbus_vld(vld2), .dbgbus_chan(chan2),
        .drop_cnt(cnt2)
    );

    ctu_dbgbus_arb_rptr #(.NCH(4), .DW(40), .DEPTH(4), .CW(2)) u_d4 (
        .rclk(clk), .rst(rst), .mode_rr(mode_rr), .freeze(freeze), .clr_cnt(clr_cnt),
        .dbgbus_in(bus), .dbgbus_out(out4), .dbgbus_vld(vld4), .dbgbus_chan(chan4),
        .drop_cnt(cnt4)
    );

    ctu_dbgbus_arb_rptr #(.NCH(3), .DW(8), .DEPTH(1), .CW(2)) u_n3 (
        .rclk(clk), .rst(rst), .mode_rr(1'b1), .freeze(1'b0), .clr_cnt(1'b0),
        .dbgbus_in(bus3), .dbgbus_out(out3), .dbgbus_vld(vld3), .dbgbus_chan(chan3),
        .drop_cnt(cnt3)
    );

    // Channel k carries data base+k, valid from mask bit k
    function automatic logic [163:0] pack4(input logic [3:0] m, input logic [39:0] base);
        logic [163:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*41 +: 41] = {m[k], base + 40'(k)};
        end
        return r;
    endfunction

    function automatic logic [26:0] pack3(input logic [2:0] m);
        logic [26:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            r[k*9 +: 9] = {m[k], 8'h30 + 8'(k)};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mode_rr = 1'b0; freeze = 1'b0; clr_cnt = 1'b0;
        bus = '0; bus3 = '0;
        step(); step();
        chk("rst_vld", 64'(vld2), 64'd0);
        chk("rst_out", 64'(out2), 64'd0);
        chk("rst_chan", 64'(chan2), 64'd0);
        chk("rst_cnt", 64'(cnt2), 64'd0);

        // Latency: only ch2 valid; NCH=3 twin owner resets to 2
        rst = 1'b0;
        bus  = pack4(4'b0100, 40'h12_3456_7898);
        bus3 = pack3(3'b100);
        step();                                             // E1
        chk("lat_e1_vld", 64'(vld2), 64'd0);
        chk("lat_e1_out", 64'(out2), 64'd0);
        chk("n3_e1_chan", 64'(chan3), 64'd2);
        bus3 = pack3(3'b011);
        step();                                             // E2
        chk("lat_e2_vld", 64'(vld2), 64'd1);
        chk("lat_e2_chan", 64'(chan2), 64'd2);
        chk("lat_e2_out", 64'(out2), 64'h12_3456_789A);
        chk("n3_wrap_chan", 64'(chan3), 64'd0);
        chk("n3_wrap_vld", 64'(vld3), 64'd1);

        // Fixed priority ch1 vs ch3 for 3 cycles
        bus  = pack4(4'b1010, 40'h1000);
        bus3 = pack3(3'b110);
        step();                                             // E3
        chk("fp_e3_out", 64'(out2), 64'h12_3456_789A);
        chk("fp_e3_cnt", 64'(cnt2), 64'd1);
        chk("n3_e3_chan", 64'(chan3), 64'd1);
        bus3 = pack3(3'b101);
        step();                                             // E4
        chk("fp_e4_chan", 64'(chan2), 64'd1);
        chk("fp_e4_out", 64'(out2), 64'h1001);
        chk("n3_e4_chan", 64'(chan3), 64'd2);
        bus3 = pack3(3'b001);
        step();                                             // E5
        chk("fp_e5_chan", 64'(chan2), 64'd1);
        chk("n3_e5_chan", 64'(chan3), 64'd0);
        chk("n3_cnt", 64'(cnt3), 64'd3);
        bus  = '0;
        bus3 = '0;
        step();                                             // E6
        chk("fp_e6_chan", 64'(chan2), 64'd1);
        chk("fp_e6_vld", 64'(vld2), 64'd1);
        step();                                             // E7
        chk("idle_vld", 64'(vld2), 64'd0);
        chk("idle_out", 64'(out2), 64'd0);
        chk("fp_cnt", 64'(cnt2), 64'd3);

        // Round-robin hold and wrap (owner is 1 from fixed mode)
        mode_rr = 1'b1;
        bus = pack4(4'b0001, 40'h3000);
        step();                                             // E8 grant 0
        bus = pack4(4'b1001, 40'h3000);
        step();                                             // E9 hold 0
        chk("rr_e9_chan", 64'(chan2), 64'd0);
        step();                                             // E10 hold 0
        chk("rr_e10_chan", 64'(chan2), 64'd0);
        bus = pack4(4'b1000, 40'h3000);
        step();                                             // E11 grant 3
        chk("rr_e11_chan", 64'(chan2), 64'd0);
        bus = pack4(4'b1001, 40'h3000);
        step();                                             // E12 hold 3
        chk("rr_e12_chan", 64'(chan2), 64'd3);
        chk("rr_e12_out", 64'(out2), 64'h3003);
        bus = pack4(4'b0001, 40'h3000);
        step();                                             // E13 wrap to 0
        chk("rr_hold3_chan", 64'(chan2), 64'd3);
        bus = '0;
        step();                                             // E14
        chk("rr_wrap_chan", 64'(chan2), 64'd0);
        chk("rr_wrap_out", 64'(out2), 64'h3000);
        chk("rr_cnt", 64'(cnt2), 64'd6);

        // Freeze with ch1 word at the output
        mode_rr = 1'b0;
        bus = pack4(4'b0110, 40'h5000);
        step(); step();                                     // E15, E16
        chk("frz_pre_chan", 64'(chan2), 64'd1);
        chk("frz_pre_cnt", 64'(cnt2), 64'd8);
        freeze = 1'b1;
        for (int n = 0; n < 5; n++) begin
            bus = pack4(4'(4'b1111 - n), 40'h7700 + 40'(n * 16));
            step();
            chk("frz_vld", 64'(vld2), 64'd1);
            chk("frz_chan", 64'(chan2), 64'd1);
            chk("frz_out", 64'(out2), 64'h5001);
            chk("frz_cnt", 64'(cnt2), 64'd8);
        end
        freeze = 1'b0;
        bus = pack4(4'b1000, 40'h9000);
        step();                                             // stale stage0 drains
        chk("rel_e1_out", 64'(out2), 64'h5001);
        step();
        chk("rel_e2_chan", 64'(chan2), 64'd3);
        chk("rel_e2_out", 64'(out2), 64'h9003);
        chk("rel_cnt", 64'(cnt2), 64'd8);

        // Saturation, clear while frozen, recount
        bus = pack4(4'b0011, 40'hA000);
        for (int n = 0; n < 300; n++) begin
            step();
        end
        chk("sat_cnt", 64'(cnt2), 64'd255);
        freeze = 1'b1;
        clr_cnt = 1'b1;
        step();
        chk("clr_cnt", 64'(cnt2), 64'd0);
        chk("clr_hold_out", 64'(out2), 64'hA000);
        clr_cnt = 1'b0;
        step();
        chk("clr_frz_cnt", 64'(cnt2), 64'd0);
        freeze = 1'b0;
        step();
        chk("recount", 64'(cnt2), 64'd1);

        // Reset mid-stream with the DEPTH=4 twin full of words
        mode_rr = 1'b1;
        bus = pack4(4'b1100, 40'hC000);
        step(); step(); step(); step();
        chk("d4_full_vld", 64'(vld4), 64'd1);
        chk("d4_full_chan", 64'(chan4), 64'd2);
        chk("d4_full_out", 64'(out4), 64'hC002);
        rst = 1'b1;
        step();
        chk("mrst_vld", 64'(vld2), 64'd0);
        chk("mrst_out", 64'(out2), 64'd0);
        chk("mrst_cnt", 64'(cnt2), 64'd0);
        chk("mrst_d4_vld", 64'(vld4), 64'd0);
        chk("mrst_d4_out", 64'(out4), 64'd0);
        rst = 1'b0;
        bus = pack4(4'b0110, 40'hD000);
        step();
        chk("post_e1_vld", 64'(vld2), 64'd0);
        chk("post_e1_d4_vld", 64'(vld4), 64'd0);
        step();
        chk("post_e2_chan", 64'(chan2), 64'd1);
        chk("post_e2_out", 64'(out2), 64'hD001);
        chk("post_e2_d4_vld", 64'(vld4), 64'd0);
        step();
        chk("post_e3_d4_vld", 64'(vld4), 64'd0);
        step();
        chk("post_e4_d4_vld", 64'(vld4), 64'd1);
        chk("post_e4_d4_chan", 64'(chan4), 64'd1);
        chk("post_cnt", 64'(cnt2), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctu_dbgbus_arb_rptr.md
Name: ctu_dbgbus_arb_rptr

Overview:
- Parametrised N-channel debug-bus repeater/arbiter.
- Each input channel carries a data word plus a valid bit.
- The block selects one channel per cycle, using either fixed-priority or round-robin-with-hold arbitration.
- The result passes through a configurable-depth retiming pipeline.
- Adds a freeze/capture mode and a saturating drop counter for debug observability.
- Sits between the L2/IOB debug-bus taps and the CTU debug port.

Parameters:
- NCH, 4, number of input channels; legal range 2..16.
- DW, 40, data width per channel, excluding the valid bit.
- DEPTH, 2, output pipeline stages; legal range 1..4; sets the latency in cycles.
- CW, 2, channel-id width; must equal max(1, clog2(NCH)).

Ports:
- rclk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mode_rr  input  1  arbitration mode: 0 = fixed priority, 1 = round-robin with hold.
- freeze  input  1  when 1, all state holds and inputs are ignored.
- clr_cnt  input  1  synchronous clear of drop_cnt.
- dbgbus_in  input  NCH*(DW+1)  channel k occupies bits [k*(DW+1) +: DW+1]; the MSB of each slice is the valid bit, the lower DW bits are data.
- dbgbus_out  output  DW  selected data, after the pipeline.
- dbgbus_vld  output  1  valid for dbgbus_out.
- dbgbus_chan  output  CW  index of the channel that produced dbgbus_out.
- drop_cnt  output  8  saturating count of cycles in which a valid channel lost arbitration.

Behaviour:
- Clocking and reset: one clock, rclk. Reset is synchronous and active-high on rst.
- Reset values:
  - All pipeline stages: data = 0, vld = 0, chan = 0. Hence dbgbus_out = 0, dbgbus_vld = 0, dbgbus_chan = 0.
  - drop_cnt = 0.
  - Owner register = NCH-1, so the first round-robin search starts at channel 0.
- Arbitration: combinational on the current dbgbus_in and the owner register.
  - Fixed priority (mode_rr = 0): grant the lowest-index valid channel.
  - Round-robin (mode_rr = 1), owner still valid: keep the grant on the owner (hold).
  - Round-robin (mode_rr = 1), owner not valid: grant the first valid channel searching owner+1, owner+2, ..., wrapping modulo NCH.
  - No channel valid: stage-0 vld = 0, data forced to 0, chan = 0, owner unchanged.
- Owner update: on any non-frozen cycle with a grant, the owner is set to the granted index. This applies in both modes, so switching modes keeps the history.
- Mode change: sampled every cycle. It takes effect on the arbitration performed in that same cycle; no flush occurs.
- Pipeline:
  - Stage 0 registers {vld, chan, data} of the arbitration result.
  - Stage i registers stage i-1.
  - Outputs come from stage DEPTH-1, so latency = DEPTH rising edges from input to output.
  - DEPTH = 1 is a single register with no bypass.
- Drop counter:
  - On a non-frozen cycle where the number of valid channels is >= 2, drop_cnt increments by 1.
  - drop_cnt saturates at 255; it never wraps.
- Freeze (freeze = 1):
  - All pipeline stages, the owner and drop_cnt hold their values, so the outputs are static.
  - Inputs arriving during freeze are lost; no buffering.
  - On release, the next edge resumes normal operation from the current inputs.
- Priority on each edge:
  - rst beats everything.
  - clr_cnt clears drop_cnt even while frozen; the pipeline still holds.
  - A coincident increment is discarded when clr_cnt = 1.
  - freeze then beats normal update.
- Reset mid-stream: all in-flight words are discarded. Outputs read 0/0/0 on the cycle after the rst edge.
- Width rules:
  - Channel index arithmetic is modulo NCH, not modulo 2^CW, which matters when NCH is not a power of 2.
  - Valid-channel population count is computed at clog2(NCH+1) bits.

Test Plan:
- Reset/latency: NCH = 4, DEPTH = 2; after rst, drive only ch2 valid with data 0x12_3456_789A.
  - -> dbgbus_vld = 1, dbgbus_chan = 2, dbgbus_out = 0x123456789A exactly 2 edges later.
  - -> Before that, outputs = 0.
- Fixed priority: mode_rr = 0; ch1 and ch3 valid for 3 cycles.
  - -> Every output cycle has chan = 1.
  - -> drop_cnt increases 0→3.
- Round-robin hold/wrap: mode_rr = 1; ch0 and ch3 held valid, then ch0 valid drops for 1 cycle, then rises again.
  - -> Output chan sequence: 0, 0, ..., 3 (hold on 3 while valid).
  - -> When ch3 drops, the grant wraps to 0.
  - -> With NCH = 3 and owner = 2, the search goes to 0, never to index 3.
- Freeze: freeze asserted with vld = 1, chan = 1 at the output, inputs changing for 5 cycles.
  - -> Outputs and drop_cnt constant throughout.
  - -> After release, a new word appears DEPTH edges later.
- Counter saturation/clear: two channels valid for 300 cycles.
  - -> drop_cnt = 255, held.
  - -> clr_cnt pulsed while frozen -> drop_cnt = 0 next edge.
  - -> After unfreeze it counts again from 1.
- Reset mid-stream: DEPTH = 4, words in flight, rst pulsed 1 cycle.
  - -> Next cycle dbgbus_vld = 0, dbgbus_out = 0, drop_cnt = 0, no stale word emerges.
  - -> First RR grant after reset goes to the lowest valid channel.
